axil_s_regfile: RTL and testbench
=================================

Name: axil_s_regfile

Overview:
- AXI4-Lite slave register bank that sits directly downstream of axis_lite_m, on the m_axi_* bus, in place of the VIP slave.
- Accepts single-beat writes and reads into NUM_REGS 32-bit registers.
- Exports the register contents and per-register write pulses to fabric logic.
- Gives the team a synthesizable endpoint for master bring-up and for system use.

Parameters:
- ADDR_W, 32, width of awaddr/araddr
- NUM_REGS, 16, number of 32-bit registers; power of two, minimum 2
- RST_VAL, 32'h0000_0000, reset value of every register

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous reset, active-high
- s_axi_awaddr  in  ADDR_W  write address
- s_axi_awprot  in  3  ignored
- s_axi_awvalid  in  1  AW valid
- s_axi_awready  out  1  AW ready
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte strobes
- s_axi_wvalid  in  1  W valid
- s_axi_wready  out  1  W ready
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  B valid
- s_axi_bready  in  1  B ready
- s_axi_araddr  in  ADDR_W  read address
- s_axi_arprot  in  3  ignored
- s_axi_arvalid  in  1  AR valid
- s_axi_arready  out  1  AR ready
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid  out  1  R valid
- s_axi_rready  in  1  R ready
- regs_o  out  32*NUM_REGS  flattened register contents; reg i at [32i+31:32i]
- wr_pulse_o  out  NUM_REGS  one-cycle pulse on the cycle reg i is updated

Behaviour:
- Clocking and reset:
  - One clock, aclk.
  - areset is synchronous and active-high, sampled on posedge aclk.
  - Reset values: all registers = RST_VAL; awready = wready = 1; bvalid = rvalid = 0; bresp = rresp = 0; rdata = 0; wr_pulse_o = 0.
  - Reset mid-transaction aborts it; no response is issued afterwards.
- Address decode:
  - index = addr[$clog2(NUM_REGS)+1:2]; addr[1:0] is ignored.
  - A request is in range only when every addr bit above the index field is 0.
- Write FSM states: W_IDLE, W_GOT_AW, W_GOT_W, W_RESP.
  - AW and W are accepted independently, in either order or in the same cycle.
  - awready deasserts once AW is captured; wready deasserts once W is captured.
  - When both are captured, the register commits on the next posedge and bvalid asserts in that same cycle (state W_RESP).
  - Commit uses byte-wise merge: byte b is updated only when wstrb[b] = 1. wr_pulse_o[index] is high for that one cycle.
  - Strobe 4'b0000 updates no byte and raises no pulse; the response is still issued.
  - bvalid holds until bready. awready and wready reassert the cycle after the B handshake.
  - One write outstanding at a time.
- Read FSM states: R_IDLE, R_DATA.
  - arready = 1 in R_IDLE.
  - On the AR handshake, rdata and rresp are registered; rvalid asserts the next cycle.
  - rvalid, rdata and rresp hold stable until rready. arready reasserts the cycle after the R handshake.
- Simultaneous events:
  - Read and write to the same register in the same cycle: the read returns the pre-write value.
  - Read and write channels never stall each other.
- Response codes: OKAY = 2'b00, SLVERR = 2'b10.

Optional Feature:
- Macro: AXIL_S_REGFILE_SLVERR_EN.
- Defined: out-of-range writes update nothing and respond bresp = SLVERR. Out-of-range reads return rdata = 0, rresp = SLVERR.
- Undefined: out-of-range writes are silently dropped with OKAY. Out-of-range reads return 0 with OKAY.
- In-range behaviour is identical in both builds.

Decomposition:
- Shared package axil_pkg holds:
  - resp constants AXI_RESP_OKAY and AXI_RESP_SLVERR
  - wr_state_t and rd_state_t enums
  - AXIL_DATA_W = 32 and AXIL_STRB_W = 4
- One sub-module, axil_s_wr_chan: the AW/W/B handshake FSM. It outputs a commit strobe, the index and an in-range flag.
- The read path and the register array stay in the top level.

Test Plan:
- Write 0x5AA5_A55A to 0x0000_0004 with strb 4'hF, then read 0x0000_0004 -> bresp = OKAY; wr_pulse_o[1] pulses once; rdata = 0x5AA5_A55A; regs_o[63:32] = 0x5AA5_A55A.
- Reg 2 holds 0xFFFF_FFFF; write 0x1234_5678 to 0x8 with strb 4'b0011 -> reg 2 = 0xFFFF_5678.
- Present W two cycles before AW (0xC, 0xCAFE_F00D) -> wready drops after W accept; commit and bvalid follow the AW handshake; reg 3 = 0xCAFE_F00D.
- Read 0x0000_0004 with rready held low 5 cycles -> rvalid and rdata stay stable for all 5 cycles; a single beat completes when rready rises.
- Write 0xAAAA_BBBB to address 0xAAAA_BBB8 (out of range) -> with SLVERR_EN: bresp = 2'b10 and no wr_pulse_o; without: bresp = 2'b00; all registers unchanged in both builds.
- Assert areset while bvalid = 1 -> the next cycle has bvalid = 0, awready = wready = 1 and all registers = RST_VAL.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the axil_s_regfile slice.
// Contents:
//   AXIL_DATA_W / AXIL_STRB_W   data and strobe widths of the bus
//   AXI_RESP_OKAY / _SLVERR     B/R response codes
//   wr_state_t / rd_state_t     write- and read-channel FSM encodings
//   strb_merge()                byte-wise merge of new data into an old word
package axil_pkg;

    localparam int AXIL_DATA_W = 32;
    localparam int AXIL_STRB_W = 4;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_GOT_AW = 2'd1,
        W_GOT_W  = 2'd2,
        W_RESP   = 2'd3
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Bytes whose strobe is set come from new_val, the rest keep old_val.
    function automatic logic [AXIL_DATA_W-1:0] strb_merge(
        input logic [AXIL_DATA_W-1:0] old_val,
        input logic [AXIL_DATA_W-1:0] new_val,
        input logic [AXIL_STRB_W-1:0] strb
    );
        logic [AXIL_DATA_W-1:0] mask;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/axil_s_regfile_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R channels) without clock/reset.
// Modports:
//   master  drives addresses, write data, valids and bready/rready
//   slave   drives readies, responses and read data
// Handshake rule on every channel: a beat transfers on a rising clock edge
// where valid and ready are both high; a source holds valid and its payload
// stable until that edge, and ready may depend combinationally on state only.
interface axil_s_regfile_if
    import axil_pkg::*;
#(
    parameter int ADDR_W = 32
) ();

    logic [ADDR_W-1:0]      awaddr;
    logic [2:0]             awprot;
    logic                   awvalid;
    logic                   awready;
    logic [AXIL_DATA_W-1:0] wdata;
    logic [AXIL_STRB_W-1:0] wstrb;
    logic                   wvalid;
    logic                   wready;
    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready;
    logic [ADDR_W-1:0]      araddr;
    logic [2:0]             arprot;
    logic                   arvalid;
    logic                   arready;
    logic [AXIL_DATA_W-1:0] rdata;
    logic [1:0]             rresp;
    logic                   rvalid;
    logic                   rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axil_s_wr_chan.sv
// AXI4-Lite write-channel handshake FSM (AW, W, B).
// AW and W are accepted independently in any order; once both have been
// taken, commit_o pulses for the cycle of the final handshake and the FSM
// enters W_RESP, so the register update and bvalid appear after the same edge.
// Optional feature: AXIL_S_REGFILE_SLVERR_EN makes out-of-range writes
// answer SLVERR instead of OKAY.
// Ports:
//   aclk, areset                      clock, synchronous active-high reset
//   awaddr/awvalid/awready            write address channel
//   wdata/wstrb/wvalid/wready         write data channel
//   bresp/bvalid/bready               write response channel
//   commit_o                          one-cycle write strobe to the array
//   idx_o, in_range_o                 decoded register index and range flag
//   wdata_o, wstrb_o                  data/strobe belonging to the commit
//   state_o                           current FSM state (debug)
module axil_s_wr_chan
    import axil_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [ADDR_W-1:0]            awaddr,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [AXIL_DATA_W-1:0]       wdata,
    input  logic [AXIL_STRB_W-1:0]       wstrb,
    input  logic                         wvalid,
    output logic                         wready,
    output logic [1:0]                   bresp,
    output logic                         bvalid,
    input  logic                         bready,
    output logic                         commit_o,
    output logic [$clog2(NUM_REGS)-1:0]  idx_o,
    output logic                         in_range_o,
    output logic [AXIL_DATA_W-1:0]       wdata_o,
    output logic [AXIL_STRB_W-1:0]       wstrb_o,
    output wr_state_t                    state_o
);

    localparam int IDX_W = $clog2(NUM_REGS);

    wr_state_t              state_q, state_d;
    logic [ADDR_W-1:0]      addr_q;
    logic [AXIL_DATA_W-1:0] data_q;
    logic [AXIL_STRB_W-1:0] strb_q;
    logic [1:0]             bresp_q;
    logic [ADDR_W-1:0]      cur_addr;
    logic                   aw_hs;
    logic                   w_hs;
    logic                   commit;

    assign awready = (state_q == W_IDLE) || (state_q == W_GOT_W);
    assign wready  = (state_q == W_IDLE) || (state_q == W_GOT_AW);
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    state_d = W_RESP;
                    commit  = 1'b1;
                end else if (aw_hs) begin
                    state_d = W_GOT_AW;
                end else if (w_hs) begin
                    state_d = W_GOT_W;
                end
            end
            W_GOT_AW: begin
                if (w_hs) begin
                    state_d = W_RESP;
                    commit  = 1'b1;
                end
            end
            W_GOT_W: begin
                if (aw_hs) begin
                    state_d = W_RESP;
                    commit  = 1'b1;
                end
            end
            W_RESP: begin
                if (bready) state_d = W_IDLE;
            end
            default: state_d = W_IDLE;
        endcase
    end

    // On the commit cycle a channel captured earlier comes from its holding
    // register; the channel completing this cycle comes straight off the bus.
    assign cur_addr   = (state_q == W_GOT_AW) ? addr_q : awaddr;
    assign wdata_o    = (state_q == W_GOT_W)  ? data_q : wdata;
    assign wstrb_o    = (state_q == W_GOT_W)  ? strb_q : wstrb;
    assign idx_o      = cur_addr[IDX_W+1:2];
    assign in_range_o = (cur_addr >> (IDX_W + 2)) == '0;
    assign commit_o   = commit;
    assign bvalid     = (state_q == W_RESP);
    assign bresp      = bresp_q;
    assign state_o    = state_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= W_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            bresp_q <= AXI_RESP_OKAY;
        end else begin
            state_q <= state_d;
            if (aw_hs) addr_q <= awaddr;
            if (w_hs) begin
                data_q <= wdata;
                strb_q <= wstrb;
            end
            if (commit) begin
`ifdef AXIL_S_REGFILE_SLVERR_EN
                bresp_q <= in_range_o ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
`else
                bresp_q <= AXI_RESP_OKAY;
`endif
            end
        end
    end

endmodule

// File: rtl/axil_s_regfile.sv
// AXI4-Lite slave register bank of NUM_REGS 32-bit registers.
// Register i lives at byte address 4*i; addr[1:0] is ignored and any set bit
// above the index field makes the access out of range. Out-of-range writes
// never touch the array; out-of-range reads return zero.
// Optional feature: AXIL_S_REGFILE_SLVERR_EN answers out-of-range accesses
// with SLVERR (default build answers OKAY).
// Ports:
//   aclk, areset   clock, synchronous active-high reset
//   s_axi          AXI4-Lite slave bus (axil_s_regfile_if.slave)
//   regs_o         flattened register contents, reg i at [32i+31:32i]
//   wr_pulse_o     one-cycle pulse in the cycle register i shows new data
//   wr_state_o     write FSM state (debug)
//   rd_state_o     read FSM state (debug)
module axil_s_regfile
    import axil_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter int          NUM_REGS = 16,
    parameter logic [31:0] RST_VAL  = 32'h0000_0000
) (
    input  logic                          aclk,
    input  logic                          areset,
    axil_s_regfile_if.slave               s_axi,
    output logic [AXIL_DATA_W*NUM_REGS-1:0] regs_o,
    output logic [NUM_REGS-1:0]           wr_pulse_o,
    output wr_state_t                     wr_state_o,
    output rd_state_t                     rd_state_o
);

    localparam int IDX_W = $clog2(NUM_REGS);

    logic [AXIL_DATA_W-1:0] regs [NUM_REGS];

    logic                   wr_commit;
    logic [IDX_W-1:0]       wr_idx;
    logic                   wr_in_range;
    logic [AXIL_DATA_W-1:0] wr_data;
    logic [AXIL_STRB_W-1:0] wr_strb;

    logic unused_prot;
    assign unused_prot = ^{s_axi.awprot, s_axi.arprot};

    axil_s_wr_chan #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_wr_chan (
        .aclk       (aclk),
        .areset     (areset),
        .awaddr     (s_axi.awaddr),
        .awvalid    (s_axi.awvalid),
        .awready    (s_axi.awready),
        .wdata      (s_axi.wdata),
        .wstrb      (s_axi.wstrb),
        .wvalid     (s_axi.wvalid),
        .wready     (s_axi.wready),
        .bresp      (s_axi.bresp),
        .bvalid     (s_axi.bvalid),
        .bready     (s_axi.bready),
        .commit_o   (wr_commit),
        .idx_o      (wr_idx),
        .in_range_o (wr_in_range),
        .wdata_o    (wr_data),
        .wstrb_o    (wr_strb),
        .state_o    (wr_state_o)
    );

    // Register array. An all-zero strobe changes nothing, so it also raises
    // no pulse even though the write itself still gets a response.
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL;
            wr_pulse_o <= '0;
        end else begin
            wr_pulse_o <= '0;
            if (wr_commit && wr_in_range && (|wr_strb)) begin
                regs[wr_idx]       <= strb_merge(regs[wr_idx], wr_data, wr_strb);
                wr_pulse_o[wr_idx] <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
        assign regs_o[AXIL_DATA_W*gi +: AXIL_DATA_W] = regs[gi];
    end

    // Read path. rdata samples the array on the AR edge, so a write
    // committing on that same edge is not visible to this read.
    rd_state_t              rd_q, rd_d;
    logic                   ar_hs;
    logic [IDX_W-1:0]       ar_idx;
    logic                   ar_in_range;
    logic [AXIL_DATA_W-1:0] rdata_q;
    logic [1:0]             rresp_q;

    assign s_axi.arready = (rd_q == R_IDLE);
    assign s_axi.rvalid  = (rd_q == R_DATA);
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;
    assign ar_hs         = s_axi.arvalid && s_axi.arready;
    assign ar_idx        = s_axi.araddr[IDX_W+1:2];
    assign ar_in_range   = (s_axi.araddr >> (IDX_W + 2)) == '0;
    assign rd_state_o    = rd_q;

    always_comb begin
        rd_d = rd_q;
        case (rd_q)
            R_IDLE:  if (ar_hs) rd_d = R_DATA;
            R_DATA:  if (s_axi.rready) rd_d = R_IDLE;
            default: rd_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            rd_q    <= R_IDLE;
            rdata_q <= '0;
            rresp_q <= AXI_RESP_OKAY;
        end else begin
            rd_q <= rd_d;
            if (ar_hs) begin
                rdata_q <= ar_in_range ? regs[ar_idx] : '0;
`ifdef AXIL_S_REGFILE_SLVERR_EN
                rresp_q <= ar_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
`else
                rresp_q <= AXI_RESP_OKAY;
`endif
            end
        end
    end

endmodule

// File: tb/tb_axil_s_regfile.sv
// Testbench for axil_s_regfile: directed scenarios plus randomized
// write/read traffic, checked against an array model of the register bank.
module tb_axil_s_regfile;
    import axil_pkg::*;

    localparam int          ADDR_W   = 32;
    localparam int          NUM_REGS = 16;
    localparam logic [31:0] RST_VAL  = 32'h0000_0000;

    // ---------------- clock / reset ----------------
    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    axil_s_regfile_if #(.ADDR_W(ADDR_W)) bus ();

    logic [32*NUM_REGS-1:0] regs_o;
    logic [NUM_REGS-1:0]    wr_pulse_o;
    wr_state_t              wr_state;
    rd_state_t              rd_state;

    axil_s_regfile #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .RST_VAL  (RST_VAL)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .s_axi      (bus),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse_o),
        .wr_state_o (wr_state),
        .rd_state_o (rd_state)
    );

    // ---------------- model / scoreboard ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model [NUM_REGS];
    int          pulse_cnt [NUM_REGS];
    logic [31:0] exp_q [$];

    initial for (int i = 0; i < NUM_REGS; i++) pulse_cnt[i] = 0;

    always @(negedge aclk) begin
        for (int i = 0; i < NUM_REGS; i++)
            if (wr_pulse_o[i] === 1'b1) pulse_cnt[i] = pulse_cnt[i] + 1;
    end

    function automatic int pulse_total();
        int s = 0;
        for (int i = 0; i < NUM_REGS; i++) s += pulse_cnt[i];
        return s;
    endfunction

    function automatic bit in_range(input logic [31:0] addr);
        return addr < NUM_REGS * 4;
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] addr);
`ifdef AXIL_S_REGFILE_SLVERR_EN
        return in_range(addr) ? 2'b00 : 2'b10;
`else
        return 2'b00;
`endif
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NUM_REGS; i++) model[i] = RST_VAL;
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb);
        int idx;
        if (!in_range(addr)) return;
        idx = addr / 4;
        for (int b = 0; b < 4; b++)
            if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
    endfunction

    function automatic logic [32*NUM_REGS-1:0] model_flat();
        logic [32*NUM_REGS-1:0] v;
        for (int i = 0; i < NUM_REGS; i++) v[32*i +: 32] = model[i];
        return v;
    endfunction

    // ---------------- driver tasks (entered and left on a negedge) -------
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int budget = 0;
        bit aw_hs, w_hs;
        bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
        while ((bus.awvalid || bus.wvalid) && budget < 50) begin
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            @(negedge aclk);
            if (aw_hs) bus.awvalid = 1'b0;
            if (w_hs)  bus.wvalid  = 1'b0;
            budget++;
        end
        budget = 0;
        while (bus.bvalid !== 1'b1 && budget < 50) begin
            @(negedge aclk);
            budget++;
        end
        if (bus.bvalid !== 1'b1) begin
            checks++; failures++;
            $display("FAIL write_timeout addr=%h bvalid=%b required=1", addr, bus.bvalid);
        end
        resp = bus.bresp;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(negedge aclk);
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int budget = 0;
        bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
        while (bus.arready !== 1'b1 && budget < 50) begin
            @(negedge aclk);
            budget++;
        end
        @(negedge aclk);
        bus.arvalid = 1'b0;
        budget = 0;
        while (bus.rvalid !== 1'b1 && budget < 50) begin
            @(negedge aclk);
            budget++;
        end
        if (bus.rvalid !== 1'b1) begin
            checks++; failures++;
            $display("FAIL read_timeout addr=%h rvalid=%b required=1", addr, bus.rvalid);
        end
        data = bus.rdata;
        resp = bus.rresp;
        @(negedge aclk);
        bus.rready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        checks++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b11100) begin
            failures++;
            $display("FAIL reset_handshake aw/w/ar/b/r=%b required=11100",
                     {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
        end
        checks++;
        if ({bus.bresp, bus.rresp, bus.rdata} !== 36'h0) begin
            failures++;
            $display("FAIL reset_resp bresp=%b rresp=%b rdata=%h required=0",
                     bus.bresp, bus.rresp, bus.rdata);
        end
        checks++;
        if (regs_o !== {NUM_REGS{RST_VAL}} || wr_pulse_o !== '0) begin
            failures++;
            $display("FAIL reset_regs regs=%h pulse=%h required regs=%h pulse=0",
                     regs_o, wr_pulse_o, {NUM_REGS{RST_VAL}});
        end
        checks++;
        if (wr_state !== W_IDLE || rd_state !== R_IDLE) begin
            failures++;
            $display("FAIL reset_state wr=%0d rd=%0d required 0 0", wr_state, rd_state);
        end
    endtask

    task automatic test_basic();
        logic [1:0]  resp;
        logic [31:0] data;
        int          p0 = pulse_cnt[1];
        axi_write(32'h4, 32'h5AA5_A55A, 4'hF, resp);
        model_write(32'h4, 32'h5AA5_A55A, 4'hF);
        checks++;
        if (resp !== AXI_RESP_OKAY) begin
            failures++; $display("FAIL basic_bresp got=%b required=00", resp);
        end
        @(negedge aclk);
        checks++;
        if (pulse_cnt[1] - p0 != 1) begin
            failures++; $display("FAIL basic_pulse got=%0d required=1", pulse_cnt[1] - p0);
        end
        axi_read(32'h4, data, resp);
        checks++;
        if (data !== 32'h5AA5_A55A || resp !== AXI_RESP_OKAY) begin
            failures++;
            $display("FAIL basic_read rdata=%h rresp=%b required=5aa5a55a/00", data, resp);
        end
        checks++;
        if (regs_o[63:32] !== 32'h5AA5_A55A) begin
            failures++; $display("FAIL basic_regs_o got=%h required=5aa5a55a", regs_o[63:32]);
        end
    endtask

    task automatic test_strobe();
        logic [1:0]  resp;
        logic [31:0] data;
        axi_write(32'h8, 32'hFFFF_FFFF, 4'hF, resp);
        model_write(32'h8, 32'hFFFF_FFFF, 4'hF);
        axi_write(32'h8, 32'h1234_5678, 4'b0011, resp);
        model_write(32'h8, 32'h1234_5678, 4'b0011);
        checks++;
        if (regs_o[95:64] !== 32'hFFFF_5678) begin
            failures++; $display("FAIL strobe_merge got=%h required=ffff5678", regs_o[95:64]);
        end
        axi_read(32'h8, data, resp);
        checks++;
        if (data !== 32'hFFFF_5678) begin
            failures++; $display("FAIL strobe_read got=%h required=ffff5678", data);
        end
        // All-zero strobe: response issued, nothing changes, no pulse.
        begin
            int p0 = pulse_total();
            axi_write(32'h8, 32'h0BAD_0BAD, 4'b0000, resp);
            @(negedge aclk);
            checks++;
            if (resp !== AXI_RESP_OKAY || regs_o !== model_flat() || pulse_total() != p0) begin
                failures++;
                $display("FAIL strobe_zero bresp=%b pulses=%0d required=00/%0d regs_ok=%b",
                         resp, pulse_total() - p0, 0, regs_o === model_flat());
            end
        end
    endtask

    task automatic test_w_before_aw();
        bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b0;
        @(negedge aclk);
        bus.wvalid = 1'b0;
        checks++;
        if (bus.wready !== 1'b0) begin
            failures++; $display("FAIL wfirst_wready got=%b required=0", bus.wready);
        end
        @(negedge aclk);
        checks++;
        if (bus.bvalid !== 1'b0 || regs_o[127:96] !== model[3]) begin
            failures++;
            $display("FAIL wfirst_early bvalid=%b reg3=%h required=0/%h",
                     bus.bvalid, regs_o[127:96], model[3]);
        end
        bus.awaddr = 32'hC; bus.awvalid = 1'b1;
        @(negedge aclk);
        bus.awvalid = 1'b0;
        model_write(32'hC, 32'hCAFE_F00D, 4'hF);
        checks++;
        if (bus.bvalid !== 1'b1 || regs_o[127:96] !== 32'hCAFE_F00D || bus.awready !== 1'b0) begin
            failures++;
            $display("FAIL wfirst_commit bvalid=%b reg3=%h awready=%b required=1/cafef00d/0",
                     bus.bvalid, regs_o[127:96], bus.awready);
        end
        bus.bready = 1'b1;
        @(negedge aclk);
        bus.bready = 1'b0;
        checks++;
        if ({bus.bvalid, bus.awready, bus.wready} !== 3'b011) begin
            failures++;
            $display("FAIL wfirst_done b/aw/w=%b required=011", {bus.bvalid, bus.awready, bus.wready});
        end
    endtask

    task automatic test_read_backpressure();
        bus.araddr = 32'h4; bus.arvalid = 1'b1; bus.rready = 1'b0;
        @(negedge aclk);
        bus.arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.rvalid !== 1'b1 || bus.rdata !== model[1] || bus.arready !== 1'b0) begin
                failures++;
                $display("FAIL rhold_cycle%0d rvalid=%b rdata=%h arready=%b required=1/%h/0",
                         i, bus.rvalid, bus.rdata, bus.arready, model[1]);
            end
            @(negedge aclk);
        end
        bus.rready = 1'b1;
        @(negedge aclk);
        bus.rready = 1'b0;
        checks++;
        if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin
            failures++;
            $display("FAIL rhold_single rvalid=%b arready=%b required=0/1", bus.rvalid, bus.arready);
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0]  resp;
        logic [31:0] data;
        int          p0 = pulse_total();
        axi_write(32'hAAAA_BBB8, 32'hAAAA_BBBB, 4'hF, resp);
        @(negedge aclk);
        checks++;
        if (resp !== exp_resp(32'hAAAA_BBB8)) begin
            failures++;
            $display("FAIL oor_bresp got=%b required=%b", resp, exp_resp(32'hAAAA_BBB8));
        end
        checks++;
        if (regs_o !== model_flat() || pulse_total() != p0) begin
            failures++;
            $display("FAIL oor_unchanged pulses=%0d required=0 regs=%h model=%h",
                     pulse_total() - p0, regs_o, model_flat());
        end
        axi_read(32'hAAAA_BBB8, data, resp);
        checks++;
        if (data !== 32'h0 || resp !== exp_resp(32'hAAAA_BBB8)) begin
            failures++;
            $display("FAIL oor_read rdata=%h rresp=%b required=0/%b",
                     data, resp, exp_resp(32'hAAAA_BBB8));
        end
    endtask

    task automatic test_same_cycle_rw();
        logic [1:0]  resp;
        logic [31:0] old_val;
        axi_write(32'h14, 32'h1111_2222, 4'hF, resp);
        model_write(32'h14, 32'h1111_2222, 4'hF);
        old_val = model[5];
        bus.awaddr = 32'h14; bus.wdata = 32'h3333_4444; bus.wstrb = 4'hF;
        bus.araddr = 32'h14;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        bus.bready = 1'b1; bus.rready = 1'b1;
        checks++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
            failures++;
            $display("FAIL rw_ready aw/w/ar=%b required=111", {bus.awready, bus.wready, bus.arready});
        end
        @(negedge aclk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        checks++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== old_val || bus.bvalid !== 1'b1) begin
            failures++;
            $display("FAIL rw_preval rvalid=%b rdata=%h bvalid=%b required=1/%h/1",
                     bus.rvalid, bus.rdata, bus.bvalid, old_val);
        end
        @(negedge aclk);
        bus.bready = 1'b0; bus.rready = 1'b0;
        model_write(32'h14, 32'h3333_4444, 4'hF);
        checks++;
        if (regs_o[191:160] !== 32'h3333_4444) begin
            failures++; $display("FAIL rw_written got=%h required=33334444", regs_o[191:160]);
        end
    endtask

    task automatic test_random();
        logic [1:0]  resp;
        logic [31:0] addr, data, rd;
        logic [3:0]  strb;
        int          p0, exp_p;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 5) == 0) addr = $urandom() | 32'h0000_0100;
            else                           addr = $urandom_range(0, NUM_REGS * 4 - 1);
            data = $urandom();
            strb = 4'($urandom_range(0, 15));
            p0 = pulse_total();
            exp_p = (in_range(addr) && strb != 4'b0) ? 1 : 0;
            axi_write(addr, data, strb, resp);
            model_write(addr, data, strb);
            @(negedge aclk);
            checks++;
            if (resp !== exp_resp(addr) || pulse_total() - p0 != exp_p) begin
                failures++;
                $display("FAIL rand_write%0d addr=%h bresp=%b pulses=%0d required=%b/%0d",
                         it, addr, resp, pulse_total() - p0, exp_resp(addr), exp_p);
            end
            if ($urandom_range(0, 4) == 0) addr = $urandom() | 32'h0000_0200;
            else                           addr = $urandom_range(0, NUM_REGS * 4 - 1);
            exp_q.push_back(in_range(addr) ? model[addr / 4] : 32'h0);
            axi_read(addr, rd, resp);
            checks++;
            begin
                logic [31:0] exp_d = exp_q.pop_front();
                if (rd !== exp_d || resp !== exp_resp(addr)) begin
                    failures++;
                    $display("FAIL rand_read%0d addr=%h rdata=%h rresp=%b required=%h/%b",
                             it, addr, rd, resp, exp_d, exp_resp(addr));
                end
            end
        end
        checks++;
        if (regs_o !== model_flat()) begin
            failures++; $display("FAIL rand_final regs=%h required=%h", regs_o, model_flat());
        end
    endtask

    task automatic test_reset_mid_write();
        bus.awaddr = 32'h18; bus.wdata = 32'h7777_8888; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
        @(negedge aclk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        checks++;
        if (bus.bvalid !== 1'b1) begin
            failures++; $display("FAIL rstmid_pre bvalid=%b required=1", bus.bvalid);
        end
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        model_reset();
        checks++;
        if ({bus.bvalid, bus.awready, bus.wready} !== 3'b011 || regs_o !== model_flat()) begin
            failures++;
            $display("FAIL rstmid_after b/aw/w=%b required=011 regs=%h required=%h",
                     {bus.bvalid, bus.awready, bus.wready}, regs_o, model_flat());
        end
        bus.bready = 1'b1;
        repeat (3) @(negedge aclk);
        bus.bready = 1'b0;
        checks++;
        if (bus.bvalid !== 1'b0 || wr_pulse_o !== '0) begin
            failures++;
            $display("FAIL rstmid_noresp bvalid=%b pulse=%h required=0/0", bus.bvalid, wr_pulse_o);
        end
    endtask

    // ---------------- sequencer ----------------
    initial begin
        areset = 1'b1;
        bus.awaddr = '0; bus.awprot = 3'b000; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = 3'b000; bus.arvalid = 1'b0; bus.rready = 1'b0;
        model_reset();
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        test_reset();
        test_basic();
        test_strobe();
        test_w_before_aw();
        test_read_backpressure();
        test_out_of_range();
        test_same_cycle_rw();
        test_random();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
